// File: rtl/gb_pkg.sv
// Shared definitions for the interrupt path: source indices, vector base and
// register addresses of IF/IE on the I/O bus.
package gb_pkg;

    localparam int IRQ_NUM_SRC = 5;

    typedef enum logic [2:0] {
        VBLANK = 3'd0,
        STAT   = 3'd1,
        TIMER  = 3'd2,
        SERIAL = 3'd3,
        JOYPAD = 3'd4
    } irq_src_e;

    localparam logic [7:0]  IRQ_VEC_BASE = 8'h40;
    localparam logic [15:0] IF_ADDR      = 16'hFF0F;
    localparam logic [15:0] IE_ADDR      = 16'hFFFF;

    // Handler low byte: 0x40 + 8 * source index.
    function automatic logic [7:0] irq_vec(input logic [2:0] sel);
        return IRQ_VEC_BASE + {2'b00, sel, 3'b000};
    endfunction

endpackage

// File: rtl/irq_priority_enc.sv
// Fixed-priority encoder: lowest set bit of pend_i wins (V-blank highest).
module irq_priority_enc #(
    parameter int N = 5
) (
    input  logic [N-1:0] pend_i,
    output logic [2:0]   sel_o,
    output logic         any_o
);

    always_comb begin
        sel_o = '0;
        // Scan downward so the lowest pending index is the last one written.
        for (int i = N - 1; i >= 0; i--) begin
            if (pend_i[i]) sel_o = 3'(i);
        end
        any_o = |pend_i;
    end

endmodule

// File: rtl/interrupt_controller.sv
// IF/IE registers, IME with delayed EI, priority selection and the dispatch
// handshake towards the CPU core; wake drives HALT/STOP exit.
module interrupt_controller
    import gb_pkg::*;
#(
    parameter int NUM_SRC = IRQ_NUM_SRC
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               cpu_en,
    input  logic [NUM_SRC-1:0] req,
    input  logic               reg_select,
    output logic [7:0]         rdata,
    input  logic [7:0]         wdata,
    input  logic               write,
    input  logic               ei,
    input  logic               di,
    input  logic               reti,
    input  logic               instr_boundary,
    output logic               irq,
    output logic [7:0]         irq_vector,
    input  logic               irq_ack,
    output logic               wake
);

    logic [NUM_SRC-1:0] if_q, if_d;
    logic [7:0]         ie_q, ie_d;
    logic               ime_q, ime_d;
    logic               ei_pending_q, ei_pending_d;

    logic [NUM_SRC-1:0] pend;
    logic [2:0]         sel;
    logic               any_pend;
    logic               ack_fire;

    assign pend = if_q & ie_q[NUM_SRC-1:0];

    irq_priority_enc #(.N(NUM_SRC)) u_prio (
        .pend_i (pend),
        .sel_o  (sel),
        .any_o  (any_pend)
    );

    assign irq        = ime_q & any_pend;
    assign irq_vector = any_pend ? irq_vec(sel) : 8'h00;
    assign wake       = any_pend;
    assign rdata      = reg_select ? ie_q : {3'b111, if_q};

    // An ack only counts while a dispatch is actually being offered.
    assign ack_fire = irq_ack & irq;

    always_comb begin
        if_d         = if_q | req;
        ie_d         = ie_q;
        ime_d        = ime_q;
        ei_pending_d = ei_pending_q;

        // Same-cycle requests are OR-ed in last so they are never lost.
        if (write && !reg_select) begin
            if_d = wdata[NUM_SRC-1:0] | req;
        end else if (ack_fire) begin
            if_d = (if_q & ~({{(NUM_SRC-1){1'b0}}, 1'b1} << sel)) | req;
        end

        if (write && reg_select) ie_d = wdata;

        if (di || ack_fire) begin
            ime_d        = 1'b0;
            ei_pending_d = 1'b0;
        end else if (reti) begin
            ime_d        = 1'b1;
            ei_pending_d = 1'b0;
        end else if (ei) begin
            ei_pending_d = 1'b1;
        end else if (instr_boundary && ei_pending_q) begin
            ime_d        = 1'b1;
            ei_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            if_q         <= '0;
            ie_q         <= '0;
            ime_q        <= 1'b0;
            ei_pending_q <= 1'b0;
        end else if (cpu_en) begin
            if_q         <= if_d;
            ie_q         <= ie_d;
            ime_q        <= ime_d;
            ei_pending_q <= ei_pending_d;
        end
    end

endmodule

// File: tb/tb_interrupt_controller.sv
// Directed and randomized checks of interrupt_controller against a
// behavioural model of the IF/IE/IME rules.
module tb_interrupt_controller;
  import gb_pkg::*;

  // Handshake: inputs change just after the falling edge, outputs are checked
  // 1 time unit later, and state advances on the rising edge.
  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cpu_en = 1'b1;
  logic [4:0] req = '0;
  logic       reg_select = 1'b0;
  logic [7:0] rdata;
  logic [7:0] wdata = '0;
  logic       write = 1'b0;
  logic       ei = 1'b0;
  logic       di = 1'b0;
  logic       reti = 1'b0;
  logic       instr_boundary = 1'b0;
  logic       irq;
  logic [7:0] irq_vector;
  logic       irq_ack = 1'b0;
  logic       wake;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  int m_if = 0;
  int m_ie = 0;
  int m_ime = 0;
  int m_eip = 0;

  interrupt_controller dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cpu_en         (cpu_en),
    .req            (req),
    .reg_select     (reg_select),
    .rdata          (rdata),
    .wdata          (wdata),
    .write          (write),
    .ei             (ei),
    .di             (di),
    .reti           (reti),
    .instr_boundary (instr_boundary),
    .irq            (irq),
    .irq_vector     (irq_vector),
    .irq_ack        (irq_ack),
    .wake           (wake)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic int m_pend();
    return m_if & m_ie & 31;
  endfunction

  function automatic int m_sel();
    int p;
    p = m_pend();
    for (int i = 0; i < 5; i++) if (p[i]) return i;
    return -1;
  endfunction

  function automatic int m_irq();
    return (m_ime != 0 && m_pend() != 0) ? 1 : 0;
  endfunction

  function automatic int m_vec();
    return (m_sel() < 0) ? 0 : 64 + 8 * m_sel();
  endfunction

  function automatic int m_rdata();
    return reg_select ? m_ie : (224 + m_if);
  endfunction

  task automatic model_update();
    int nif, nie, nime, neip, s, fire;
    if (!reset_n) begin
      m_if = 0; m_ie = 0; m_ime = 0; m_eip = 0;
    end else if (cpu_en) begin
      s    = m_sel();
      fire = (irq_ack && m_irq() != 0) ? 1 : 0;
      nie  = m_ie; nime = m_ime; neip = m_eip;
      if (write && !reg_select) nif = (int'(wdata) & 31) | int'(req);
      else if (fire != 0)       nif = (m_if & ~(1 << s)) | int'(req);
      else                      nif = m_if | int'(req);
      if (write && reg_select) nie = int'(wdata);
      if (di || fire != 0) begin nime = 0; neip = 0; end
      else if (reti)       begin nime = 1; neip = 0; end
      else if (ei)         neip = 1;
      else if (instr_boundary && m_eip != 0) begin nime = 1; neip = 0; end
      m_if = nif; m_ie = nie; m_ime = nime; m_eip = neip;
    end
  endtask

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
    end
  endtask

  task automatic chk_model();
    #1;
    chk("irq",   {7'd0, irq},  8'(m_irq()));
    chk("wake",  {7'd0, wake}, 8'(m_pend() != 0));
    chk("vec",   irq_vector,   8'(m_vec()));
    chk("rdata", rdata,        8'(m_rdata()));
  endtask

  // ---------------- driver ----------------
  task automatic tick();
    chk_model();
    @(posedge clk);
    model_update();
    @(negedge clk);
    req = '0; write = 1'b0; ei = 1'b0; di = 1'b0; reti = 1'b0;
    instr_boundary = 1'b0; irq_ack = 1'b0;
  endtask

  task automatic wr(input logic sel, input logic [7:0] data);
    reg_select = sel; wdata = data; write = 1'b1;
    tick();
  endtask

  task automatic peek(input string tag, input logic sel, input logic [7:0] exp);
    reg_select = sel;
    #1;
    chk(tag, rdata, exp);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(negedge clk);
    reset_n = 1'b0;
    tick(); tick();
    reset_n = 1'b1;

    // Reset state.
    peek("rst_if", 1'b0, 8'hE0);
    peek("rst_ie", 1'b1, 8'h00);
    chk("rst_irq", {7'd0, irq}, 8'h00);
    chk("rst_wake", {7'd0, wake}, 8'h00);
    chk("rst_vec", irq_vector, 8'h00);

    // Timer interrupt through RETI-enabled IME.
    wr(1'b1, 8'h04);
    reti = 1'b1; tick();
    req = 5'(1) << int'(TIMER); tick();
    #1;
    chk("tmr_irq", {7'd0, irq}, 8'h01);
    chk("tmr_vec", irq_vector, 8'h50);
    irq_ack = 1'b1; tick();
    #1;
    chk("tmr_ack_irq", {7'd0, irq}, 8'h00);
    peek("tmr_ack_if", 1'b0, 8'hE0);

    // Multiple pending, STAT wins.
    wr(1'b1, 8'h1F);
    reti = 1'b1; tick();
    wr(1'b0, 8'h1A);
    #1;
    chk("multi_vec", irq_vector, 8'h48);
    chk("multi_irq", {7'd0, irq}, 8'h01);
    irq_ack = 1'b1; tick();
    peek("multi_if", 1'b0, 8'hF8);
    chk("multi_irq_low", {7'd0, irq}, 8'h00);

    // EI takes effect only at the following instruction boundary.
    wr(1'b1, 8'h01);
    wr(1'b0, 8'h01);
    ei = 1'b1; tick();
    #1; chk("ei_wait0", {7'd0, irq}, 8'h00);
    tick();
    #1; chk("ei_wait1", {7'd0, irq}, 8'h00);
    instr_boundary = 1'b1; tick();
    #1; chk("ei_rise", {7'd0, irq}, 8'h01);
    irq_ack = 1'b1; tick();

    // DI between EI and boundary cancels it.
    wr(1'b0, 8'h01);
    ei = 1'b1; tick();
    di = 1'b1; tick();
    instr_boundary = 1'b1; tick();
    #1; chk("ei_di", {7'd0, irq}, 8'h00);

    // Boundary in the same cycle as EI is ignored.
    ei = 1'b1; instr_boundary = 1'b1; tick();
    #1; chk("ei_same_bnd", {7'd0, irq}, 8'h00);
    instr_boundary = 1'b1; tick();
    #1; chk("ei_next_bnd", {7'd0, irq}, 8'h01);
    irq_ack = 1'b1; tick();

    // Same-cycle collisions.
    reg_select = 1'b0; wdata = 8'h00; write = 1'b1; req = 5'b00001; tick();
    peek("coll_wr", 1'b0, 8'hE1);
    reti = 1'b1; tick();
    irq_ack = 1'b1; req = 5'b00001; tick();
    peek("coll_ack", 1'b0, 8'hE1);
    chk("coll_ack_irq", {7'd0, irq}, 8'h00);

    // Wake without IME; cpu_en low holds everything.
    wr(1'b0, 8'h00);
    wr(1'b1, 8'h10);
    req = 5'b10000; tick();
    #1;
    chk("wake_only", {7'd0, wake}, 8'h01);
    chk("wake_noirq", {7'd0, irq}, 8'h00);
    cpu_en = 1'b0; req = 5'b00001; tick();
    peek("hold_if", 1'b0, 8'hF0);
    cpu_en = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      reset_n        = ($urandom_range(0, 99) != 0);
      cpu_en         = ($urandom_range(0, 3) != 0);
      req            = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'd0;
      reg_select     = 1'($urandom_range(0, 1));
      wdata          = 8'($urandom_range(0, 255));
      write          = ($urandom_range(0, 5) == 0);
      ei             = ($urandom_range(0, 7) == 0);
      di             = ($urandom_range(0, 11) == 0);
      reti           = ($urandom_range(0, 11) == 0);
      instr_boundary = ($urandom_range(0, 2) == 0);
      irq_ack        = ($urandom_range(0, 3) == 0);
      tick();
    end
    reset_n = 1'b1;
    cpu_en = 1'b1;
    chk_model();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/interrupt_controller.md
# interrupt_controller

Central interrupt arbiter between the peripheral request sources (V-blank, LCD STAT, timer, serial, joypad) and the CPU core. Holds the IF (0xFF0F) and IE (0xFFFF) registers and the CPU master enable IME, including the delayed-EI behaviour. Selects the highest-priority enabled pending request, drives the dispatch handshake with the CPU, and raises the HALT/STOP wake signal. Sits on the I/O register bus next to the timer and divider; the timer's `timer_int` pulse is one of its inputs.

## Interface
Parameters:
- `NUM_SRC`, 5: number of interrupt sources. Fixed at 5 for DMG; not intended to change.

Ports:
- `clk`  in  1: system clock.
- `reset_n`  in  1: reset, synchronous, active-low.
- `cpu_en`  in  1: CPU clock enable. All state updates except reset are qualified by it.
- `req`  in  5: request pulses, one `cpu_en` cycle wide; bit 0 V-blank, 1 STAT, 2 timer, 3 serial, 4 joypad.
- `reg_select`  in  1: 0 selects IF, 1 selects IE.
- `rdata`  out  8: register read data (combinational).
- `wdata`  in  8: register write data.
- `write`  in  1: register write strobe.
- `ei`  in  1: CPU executed EI (pulse).
- `di`  in  1: CPU executed DI (pulse).
- `reti`  in  1: CPU executed RETI (pulse).
- `instr_boundary`  in  1: CPU is at an instruction fetch boundary (pulse).
- `irq`  out  1: dispatch request to the CPU.
- `irq_vector`  out  8: low byte of the handler address, valid while `irq` is high.
- `irq_ack`  in  1: CPU accepts the dispatch (pulse).
- `wake`  out  1: any enabled request is pending, independent of IME. Used for HALT/STOP exit.

## Operation
- State: `if_r[4:0]`, `ie_r[7:0]`, `ime`, `ei_pending`.
- `pend = if_r & ie_r[4:0]`. Priority is bit 0 highest, bit 4 lowest. `sel` is the index of the lowest set bit of `pend`.
- `irq = ime & |pend`. `irq_vector = 8'h40 + {sel, 3'b000}` (0x40, 0x48, 0x50, 0x58, 0x60). When `pend` is 0, `irq_vector = 8'h00`.
- `wake = |pend`.
- Reads: IF returns `{3'b111, if_r}`. IE returns `ie_r` with all 8 bits stored.
- IF next value, evaluated in priority order:
  - IF write: `wdata[4:0] | req`.
  - Otherwise, `irq_ack` with `irq` high: `(if_r & ~onehot(sel)) | req`.
  - Otherwise: `if_r | req`.
  - Consequence: a request arriving in the same cycle always survives, both on a same-bit ack and on a write of 0.
- IE: written from `wdata` when `reg_select == 1 & write`.
- IME / EI delay, evaluated in priority order:
  - `di`: `ime <= 0`, `ei_pending <= 0`.
  - `irq_ack` with `irq` high: `ime <= 0`, `ei_pending <= 0`.
  - `reti`: `ime <= 1`, `ei_pending <= 0`.
  - `ei`: `ei_pending <= 1`. `ime` is unchanged, and an `instr_boundary` in the same cycle is ignored.
  - `instr_boundary` with `ei_pending` set: `ime <= 1`, `ei_pending <= 0`.
  - EI while IME is already 1 leaves IME at 1.
- `irq_ack` while `irq` is low is ignored.

## Timing
- Reset values: `if_r = 0`, `ie_r = 0`, `ime = 0`, `ei_pending = 0`. Outputs: `irq = 0`, `wake = 0`, `irq_vector = 8'h00`, `rdata = 8'hE0` for IF and 8'h00 for IE.
- A `req` pulse at cycle N (with `cpu_en`) makes the IF bit visible at N+1. `irq` and `wake` follow combinationally at N+1.
- A register write at N takes effect at N+1, so `irq` and `wake` re-evaluate at N+1.
- `irq_vector` is combinational. The CPU samples it in its `irq_ack` cycle.
- After `irq_ack` at N, `irq` is low at N+1 because IME is cleared.
- EI followed by a boundary pulse at M: `irq` can rise at M+1 at the earliest.
- When `cpu_en` is low, all state holds, including `req` (a request pulse is not sampled).
- Reset in the middle of a dispatch clears everything. A CPU handshake in flight is abandoned.

## Structure
- Shared package `gb_pkg`:
  - `irq_src_e` enum: VBLANK=0, STAT=1, TIMER=2, SERIAL=3, JOYPAD=4.
  - `IRQ_VEC_BASE = 8'h40`.
  - `IF_ADDR = 16'hFF0F`, `IE_ADDR = 16'hFFFF`.
- One sub-module, `irq_priority_enc`: combinational. Maps 5-bit `pend` to `sel[2:0]` plus `any`.

## Test plan
- Reset, then read IF and IE: expect 0xE0 and 0x00. `irq`, `wake` and `irq_vector` are all 0.
- IE=0x04, IME enabled via RETI, timer `req[2]` pulse:
  - `irq` rises the next cycle with `irq_vector = 0x50`.
  - `irq_ack`: IF bit 2 clears, IME=0, `irq` low the next cycle.
- IE=0x1F, IF written to 0x1A with IME=1: expect `irq_vector = 0x48`. Ack, then IF reads 0xF8 and `irq` stays low.
- EI pulse, then the next `instr_boundary`, with IF=IE=0x01:
  - `irq` stays low until the boundary.
  - `irq` rises the cycle after the boundary.
  - A DI between the EI and the boundary keeps `irq` low.
- Same-cycle collisions:
  - `req[0]` coincides with an IF write of 0x00: IF reads 0xE1.
  - `req[0]` coincides with an ack of bit 0: bit 0 remains set.
- IME=0, IE=0x10, `req[4]`: `wake = 1` and `irq = 0`. Hold `cpu_en` low with `req` high: IF unchanged.
